// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - round-robin PCI bus arbiter with unused-grant timeout
module pci_bus_arbiter #(
    parameter int N       = 4,
    parameter int OW      = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          frame,
    input  logic          irdy,
    output logic [N-1:0]  gnt,
    output logic [OW-1:0] owner,
    output logic          bus_busy,
    output logic          timeout_pulse
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [7:0]   CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [OW-1:0] ptr;
    logic [7:0]    cnt;

    logic          bus_idle;
    logic          any_req;
    logic [OW-1:0] winner;
    logic [OW-1:0] owner_next;

    assign bus_idle = frame && irdy;
    assign any_req  = ~&req;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin : winner_sel
        logic found;
        int   idx;
        winner = ptr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && !req[idx]) begin
                winner = OW'(idx);
                found  = 1'b1;
            end
        end
    end

    // Served or timed-out owner drops to lowest priority.
    always_comb begin
        if (int'(owner) >= N - 1) begin
            owner_next = '0;
        end else begin
            owner_next = owner + OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            gnt           <= '1;
            owner         <= '0;
            bus_busy      <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gnt <= '1;
                    if (bus_idle && any_req) begin
                        gnt   <= ~(ONE_HOT0 << winner);
                        owner <= winner;
                        cnt   <= '0;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Transaction start wins over withdrawal and timeout on the same edge.
                    if (!frame) begin
                        gnt      <= '1;
                        ptr      <= owner_next;
                        bus_busy <= 1'b1;
                        state    <= ST_BUSY;
                    end else if (req[owner]) begin
                        gnt   <= '1;
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        gnt           <= '1;
                        timeout_pulse <= 1'b1;
                        ptr           <= owner_next;
                        state         <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_BUSY: begin
                    gnt <= '1;
                    if (bus_idle) begin
                        bus_busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    gnt      <= '1;
                    bus_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb/tb_pci_bus_arbiter.sv - scoreboard bench for pci_bus_arbiter
module tb_pci_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'hF;
    logic       frame = 1'b1;
    logic       irdy = 1'b1;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_pulse;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] e;

    int         m_st = 0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    logic [1:0] m_owner = 2'd0;
    logic [3:0] m_gnt = 4'hF;
    logic       m_busy = 1'b0;
    logic       m_tp = 1'b0;

    always #5 clk = ~clk;

    pci_bus_arbiter #(.N(4), .OW(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .frame(frame), .irdy(irdy),
        .gnt(gnt), .owner(owner), .bus_busy(bus_busy), .timeout_pulse(timeout_pulse)
    );

    // Drive one cycle of inputs, push the expected outputs, advance past the edge.
    task automatic step(input logic [3:0] r, input logic f, input logic i, input logic rs);
        int w;
        req = r; frame = f; irdy = i; rst = rs;
        m_tp = 1'b0;
        if (rs) begin
            m_st = 0; m_ptr = 0; m_cnt = 0; m_owner = 2'd0; m_gnt = 4'hF; m_busy = 1'b0;
        end else if (m_st == 0) begin
            if (f && i && r != 4'hF) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && !r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_gnt = 4'hF;
                m_gnt[w] = 1'b0;
                m_owner = w[1:0];
                m_cnt = 0;
                m_st = 1;
            end
        end else if (m_st == 1) begin
            if (!f) begin
                m_gnt = 4'hF; m_ptr = (int'(m_owner) + 1) % 4; m_busy = 1'b1; m_st = 2;
            end else if (r[m_owner]) begin
                m_gnt = 4'hF; m_st = 0;
            end else if (m_cnt == 15) begin
                m_gnt = 4'hF; m_tp = 1'b1; m_ptr = (int'(m_owner) + 1) % 4; m_st = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (f && i) begin
                m_busy = 1'b0; m_st = 0;
            end
        end
        exp_q.push_back({m_gnt, m_owner, m_busy, m_tp});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 12; c++) begin
            step(4'hF, 1'b1, 1'b1, c < 2);
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL reset cyc %0d: got %b want %b", c, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
        end
        n_chk++;
        if ({gnt, owner, bus_busy} !== 7'b1111_00_0) begin
            n_fail++; $display("FAIL reset_idle: got %b want 1111000", {gnt, owner, bus_busy});
        end
    endtask

    task automatic test_single;
        logic [3:0] rs[6] = '{4'b1011, 4'b1011, 4'b1011, 4'hF, 4'hF, 4'hF};
        logic       fs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            step(rs[c], fs[c], fs[c], 1'b0);
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL single cyc %0d: got %b want %b", c, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
            if (c == 0) begin
                n_chk++;
                if (gnt !== 4'b1011) begin n_fail++; $display("FAIL single_gnt: got %b want 1011", gnt); end
            end
            if (c == 2) begin
                n_chk++;
                if ({gnt, bus_busy} !== 5'b1111_1) begin n_fail++; $display("FAIL single_busy: got %b want 11111", {gnt, bus_busy}); end
            end
            if (c == 4) begin
                n_chk++;
                if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b want 0", bus_busy); end
            end
        end
    endtask

    task automatic test_round_robin;
        int order[5];
        int ngr = 0, phase = 0, t = 0, viol = 0, cyc = 0;
        logic [3:0] prev_g = 4'hF;
        logic [3:0] r;
        logic f;
        step(4'hF, 1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front(); n_chk++;
        if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
            n_fail++; $display("FAIL rr_reset: got %b want %b", {gnt, owner, bus_busy, timeout_pulse}, e);
        end
        while ((ngr < 5 || phase != 0) && cyc < 80) begin
            r = (ngr >= 5 && (phase == 0 || t >= 1)) ? 4'hF : 4'h0;
            f = !(phase == 1 && t >= 1 && t <= 3);
            step(r, f, f, 1'b0);
            cyc++;
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL rr cyc %0d: got %b want %b", cyc, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
            if (prev_g != 4'hF && gnt != 4'hF && prev_g != gnt) viol++;
            prev_g = gnt;
            if (phase == 1) begin
                t++;
                if (t == 5) phase = 0;
            end else if (gnt != 4'hF) begin
                for (int k = 0; k < 4; k++) if (!gnt[k] && ngr < 5) order[ngr] = k;
                ngr++;
                phase = 1;
                t = 0;
            end
        end
        n_chk++;
        if (ngr != 5) begin n_fail++; $display("FAIL rr_count: got %0d grants want 5", ngr); end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (order[k] != k % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 4); end
        end
        n_chk++;
        if (viol != 0) begin n_fail++; $display("FAIL rr_gap: got %0d handovers without idle want 0", viol); end
    endtask

    task automatic test_timeout;
        int low = 0;
        logic seen = 1'b0, done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step(4'b0101, 1'b1, 1'b1, 1'b0);
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL timeout cyc %0d: got %b want %b", c, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
            if (gnt[1] === 1'b0) begin
                low++; seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
                n_chk++;
                if (low != 16 || timeout_pulse !== 1'b1 || gnt !== 4'hF) begin
                    n_fail++; $display("FAIL timeout_len: got low=%0d pulse=%b gnt=%b want low=16 pulse=1 gnt=1111", low, timeout_pulse, gnt);
                end
            end
        end
        n_chk++;
        if (!done) begin n_fail++; $display("FAIL timeout_bound: got no revoke want revoke within 40 cycles"); end
        step(4'b0101, 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_chk++;
        if ({gnt, owner, bus_busy, timeout_pulse} !== e || gnt !== 4'b0111 || timeout_pulse !== 1'b0) begin
            n_fail++; $display("FAIL timeout_next: got %b want %b (gnt 0111)", {gnt, owner, bus_busy, timeout_pulse}, e);
        end
        for (int c = 0; c < 2; c++) begin
            step(4'hF, 1'b1, 1'b1, 1'b0);
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL timeout_wd cyc %0d: got %b want %b", c, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] r;
        logic f;
        for (int c = 0; c < 20; c++) begin
            r = (c == 16 || c == 19) ? 4'hF : (c >= 17 ? 4'b0011 : 4'b1011);
            f = (c != 16);
            step(r, f, 1'b1, 1'b0);
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL simul cyc %0d: got %b want %b", c, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
            if (c == 0) begin
                n_chk++;
                if (gnt !== 4'b1011) begin n_fail++; $display("FAIL simul_gnt: got %b want 1011", gnt); end
            end
            if (c == 16) begin
                n_chk++;
                if ({gnt, bus_busy, timeout_pulse} !== 6'b1111_1_0) begin
                    n_fail++; $display("FAIL simul_busy: got %b want 111110", {gnt, bus_busy, timeout_pulse});
                end
            end
            if (c == 18) begin
                n_chk++;
                if ({gnt, owner} !== 6'b0111_11) begin n_fail++; $display("FAIL simul_ptr: got %b want 011111", {gnt, owner}); end
            end
        end
    endtask

    task automatic test_reset_busy;
        logic [3:0] rs[9] = '{4'b1101, 4'b1101, 4'b1101, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'hF};
        logic       fs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 9; c++) begin
            step(rs[c], fs[c], fs[c], c == 3);
            e = exp_q.pop_front(); n_chk++;
            if ({gnt, owner, bus_busy, timeout_pulse} !== e) begin
                n_fail++; $display("FAIL rstbusy cyc %0d: got %b want %b", c, {gnt, owner, bus_busy, timeout_pulse}, e);
            end
            if (c == 2) begin
                n_chk++;
                if ({owner, bus_busy} !== 3'b01_1) begin n_fail++; $display("FAIL rstbusy_pre: got %b want 011", {owner, bus_busy}); end
            end
            if (c == 3) begin
                n_chk++;
                if ({gnt, owner, bus_busy} !== 7'b1111_00_0) begin
                    n_fail++; $display("FAIL rstbusy_rst: got %b want 1111000", {gnt, owner, bus_busy});
                end
            end
            if (c == 6) begin
                n_chk++;
                if (gnt !== 4'hF) begin n_fail++; $display("FAIL rstbusy_hold: got %b want 1111", gnt); end
            end
            if (c == 7) begin
                n_chk++;
                if ({gnt, owner} !== 6'b0111_11) begin n_fail++; $display("FAIL rstbusy_grant: got %b want 011111", {gnt, owner}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central PCI arbiter that shares the bus among up to N initiator controllers.
- Each initiator drives an active-low req and receives an active-low gnt.
- Arbitration is round-robin; there is no bus parking.
- Watches shared frame/irdy to track transaction start and bus idle.
- Revokes a grant when the granted initiator fails to start a transaction within TIMEOUT cycles.

Parameters:
N, 4, number of initiators (2..4)
OW, 2, width of owner index (N <= 2**OW)
TIMEOUT, 16, cycles a grant may stay unused before revocation (2..255)

Ports:
clk  input  1  bus clock; all state updates on posedge
rst  input  1  synchronous active-high reset
req  input  N  per-initiator request, active low
frame  input  1  shared PCI frame, active low (bench drives pulled-up value 1 when released)
irdy  input  1  shared PCI irdy, active low (same pull-up rule)
gnt  output  N  per-initiator grant, active low, registered
owner  output  OW  index of current/last granted initiator, registered
bus_busy  output  1  high while the arbiter is in BUSY
timeout_pulse  output  1  one-cycle high when a grant is revoked for timeout

Behaviour:
- Reset values:
  - gnt = all ones; owner = 0; bus_busy = 0; timeout_pulse = 0.
  - state = IDLE; round-robin pointer ptr = 0; wait counter = 0.
  - Reset takes effect at the posedge where rst=1 and overrides everything, including mid-transaction.
- All outputs are registered; at most one gnt bit is low at any time.
- bus_idle = frame==1 && irdy==1 (sampled).
- Winner selection (combinational): the first index i starting at ptr, wrapping modulo N, with req[i]==0.
- States:
  - IDLE:
    - All gnt high.
    - Advances only on a posedge where bus_idle==1 and any req is low; otherwise stays in IDLE with gnt all high. This holds even while frame/irdy are low because another agent is still finishing a transaction.
    - On advancing: gnt[winner] goes low, owner = winner, counter = 0, next state GRANT.
    - Latency: req low sampled at edge k (bus idle) -> gnt low after edge k.
  - GRANT, checked in this priority order:
    1. frame==0 sampled: gnt[owner] goes high, ptr = (owner+1) mod N, bus_busy = 1, next state BUSY.
    2. req[owner]==1 (request withdrawn): gnt high, ptr unchanged, next state IDLE.
    3. counter == TIMEOUT-1: gnt high, timeout_pulse = 1 for one cycle, ptr = (owner+1) mod N, next state IDLE.
    4. Otherwise: counter increments and gnt is held.
  - BUSY:
    - gnt all high; remains in BUSY until bus_idle==1 is sampled.
    - On bus_idle: bus_busy = 0, next state IDLE.
- Handover gap: gnt is never low on two consecutive cycles for different initiators. Any grant change passes through at least one IDLE cycle with all gnt high.
- Fairness: a served or timed-out initiator drops to lowest priority. Withdrawal without use does not rotate ptr.
- Simultaneous events in GRANT resolve by the priority order above: frame beats withdrawal and timeout.
- Counter width is 8 bits; it never wraps because TIMEOUT-1 ends the count.
- Requests arriving during BUSY are held off and served from IDLE after bus idle. No request is latched internally; req must be held low until granted.
- owner holds its value in IDLE and BUSY; it changes only on a new grant.

Test Plan:
1. Reset then idle: rst=1 two cycles, req=4'b1111, frame=irdy=1 -> gnt=4'b1111, owner=0, bus_busy=0 for 10 cycles.
2. Single grant and transaction: req[2]=0 at edge k -> gnt=4'b1011 after k. Then frame=0 at k+2 -> gnt=4'b1111, bus_busy=1. Then frame=irdy=1 -> bus_busy=0 and state IDLE next edge.
3. Round robin: all req low continuously, each grantee asserts frame 2 cycles after gnt and finishes 3 cycles later -> grant order 0,1,2,3,0. At least one all-high gnt cycle between grants.
4. Timeout: req[1]=0, frame held 1, TIMEOUT=16 -> gnt[1] low exactly 16 cycles, then high with timeout_pulse=1 for one cycle. With req[3] also low, the next grant goes to 3 after one idle cycle.
5. Simultaneous events: frame=0 on the same edge counter reaches TIMEOUT-1 and req[owner] goes high -> BUSY entered, timeout_pulse stays 0, ptr = owner+1.
6. Reset mid-BUSY: rst=1 while frame=0 -> next cycle gnt=4'b1111, bus_busy=0, owner=0, ptr=0. After rst drops, a pending req[3] is granted only once frame=irdy=1 is sampled.
